// File: rtl/fir_tcdm_rr_arbiter.sv
// Round-robin TCDM arbiter with request locking: shares one TCDM master port between
// N_REQ requesters and routes responses back in issue order through a requester-ID FIFO.
module fir_tcdm_rr_arbiter #(
    parameter int N_REQ           = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int BW              = DW / 8,
    localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_REQ-1:0]    in_req,
    output logic [N_REQ-1:0]    in_gnt,
    input  logic [N_REQ*AW-1:0] in_add,
    input  logic [N_REQ-1:0]    in_wen,
    input  logic [N_REQ*BW-1:0] in_be,
    input  logic [N_REQ*DW-1:0] in_data,
    output logic [N_REQ*DW-1:0] in_r_data,
    output logic [N_REQ-1:0]    in_r_valid,
    output logic                out_req,
    input  logic                out_gnt,
    output logic [AW-1:0]       out_add,
    output logic                out_wen,
    output logic [BW-1:0]       out_be,
    output logic [DW-1:0]       out_data,
    input  logic [DW-1:0]       out_r_data,
    input  logic                out_r_valid,
    output logic [CW-1:0]       outstanding_o,
    output logic                err_o
);

    localparam int IDW = $clog2(N_REQ);
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] lock_id;
    logic           lock_valid;
    logic [IDW-1:0] sel;
    logic           found;
    logic           lock_hit;
    logic           lock_drop;
    logic           accept;
    logic           pop;
    logic           full;
    logic           empty;
    logic [IDW-1:0] head_id;

    logic [IDW-1:0] id_fifo [MAX_OUTSTANDING];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           err_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == CW'(MAX_OUTSTANDING));
    assign empty     = (count == '0);
    assign lock_hit  = lock_valid & in_req[lock_id];
    assign lock_drop = lock_valid & ~in_req[lock_id];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel   = rr_ptr;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && in_req[(int'(rr_ptr) + i) % N_REQ]) begin
                found = 1'b1;
                sel   = IDW'((int'(rr_ptr) + i) % N_REQ);
            end
        end
        if (lock_hit) sel = lock_id;
    end

    // Gated by reset so the master port is idle while the arbiter is held in reset.
    assign out_req  = rst_ni & (|in_req) & ~full;
    assign accept   = out_req & out_gnt;
    assign out_add  = in_add[int'(sel)*AW +: AW];
    assign out_wen  = in_wen[sel];
    assign out_be   = in_be[int'(sel)*BW +: BW];
    assign out_data = in_data[int'(sel)*DW +: DW];

    always_comb begin
        in_gnt      = '0;
        in_gnt[sel] = accept;
    end

    assign head_id   = id_fifo[rd_ptr];
    assign pop       = out_r_valid & ~empty;
    assign in_r_data = {N_REQ{out_r_data}};

    always_comb begin
        in_r_valid = '0;
        if (pop) in_r_valid[head_id] = 1'b1;
    end

    // NOTE: the ID storage has no reset; occupancy is tracked by count, so stale entries are never read.
    always_ff @(posedge clk_i) begin
        if (accept) id_fifo[wr_ptr] <= sel;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr     <= '0;
            lock_id    <= '0;
            lock_valid <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr     <= ptr_inc(wr_ptr);
                rr_ptr     <= (sel == IDW'(N_REQ - 1)) ? '0 : sel + 1'b1;
                lock_valid <= 1'b0;
            end else if (out_req) begin
                lock_valid <= 1'b1;
                lock_id    <= sel;
            end else if (lock_drop) begin
                lock_valid <= 1'b0;
            end

            if (pop) rd_ptr <= ptr_inc(rd_ptr);

            if (accept && !pop)      count <= count + 1'b1;
            else if (pop && !accept) count <= count - 1'b1;

            // A dropped locked request or a response with nothing outstanding is a protocol error.
            if (lock_drop || (out_r_valid && empty)) err_q <= 1'b1;
        end
    end

    assign outstanding_o = count;
    assign err_o         = err_q;

endmodule

// File: tb/tb_fir_tcdm_rr_arbiter.sv
// Directed self-checking bench for fir_tcdm_rr_arbiter (N_REQ=2, MAX_OUTSTANDING=4).
module tb_fir_tcdm_rr_arbiter;

    localparam int N_REQ = 2;
    localparam int MAXO  = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int CW    = $clog2(MAXO + 1);

    logic                clk_i;
    logic                rst_ni;
    logic [N_REQ-1:0]    in_req;
    logic [N_REQ-1:0]    in_gnt;
    logic [N_REQ*AW-1:0] in_add;
    logic [N_REQ-1:0]    in_wen;
    logic [N_REQ*BW-1:0] in_be;
    logic [N_REQ*DW-1:0] in_data;
    logic [N_REQ*DW-1:0] in_r_data;
    logic [N_REQ-1:0]    in_r_valid;
    logic                out_req;
    logic                out_gnt;
    logic [AW-1:0]       out_add;
    logic                out_wen;
    logic [BW-1:0]       out_be;
    logic [DW-1:0]       out_data;
    logic [DW-1:0]       out_r_data;
    logic                out_r_valid;
    logic [CW-1:0]       outstanding_o;
    logic                err_o;

    int n_checks = 0;
    int n_pass   = 0;

    fir_tcdm_rr_arbiter #(
        .N_REQ(N_REQ), .MAX_OUTSTANDING(MAXO), .AW(AW), .DW(DW), .BW(BW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen),
        .in_be(in_be), .in_data(in_data), .in_r_data(in_r_data), .in_r_valid(in_r_valid),
        .out_req(out_req), .out_gnt(out_gnt), .out_add(out_add), .out_wen(out_wen),
        .out_be(out_be), .out_data(out_data), .out_r_data(out_r_data),
        .out_r_valid(out_r_valid), .outstanding_o(outstanding_o), .err_o(err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 ns later, well before the rising edge.
    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rd);
        @(negedge clk_i);
        in_req      = req;
        out_gnt     = gnt;
        out_r_valid = rv;
        out_r_data  = rd;
        #1;
    endtask

    initial begin
        rst_ni      = 1'b0;
        in_req      = '0;
        out_gnt     = 1'b0;
        out_r_valid = 1'b0;
        out_r_data  = '0;
        in_add      = {32'h0000_2000, 32'h0000_1000};
        in_wen      = 2'b10;
        in_be       = {4'hF, 4'h3};
        in_data     = {32'hBBBB_0001, 32'hAAAA_0000};

        // Reset state
        #12;
        check("rst_out_req", out_req, 0);
        check("rst_in_gnt", in_gnt, 0);
        check("rst_in_r_valid", in_r_valid, 0);
        check("rst_outstanding", outstanding_o, 0);
        check("rst_err", err_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Continuous requests from both, response one cycle after each grant
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        check("rr_c0_gnt", in_gnt, 2'b01);
        check("rr_c0_add", out_add, 32'h1000);
        for (int k = 1; k <= 4; k++) begin
            drive(2'b11, 1'b1, 1'b1, 32'h5000 + k);
            check($sformatf("rr_c%0d_gnt", k), in_gnt, (k % 2 == 1) ? 2'b10 : 2'b01);
            check($sformatf("rr_c%0d_rvalid", k), in_r_valid, (k % 2 == 1) ? 2'b01 : 2'b10);
            check($sformatf("rr_c%0d_outst", k), outstanding_o, 1);
        end
        drive(2'b00, 1'b1, 1'b1, 32'h0);
        check("rr_drain_rvalid", in_r_valid, 2'b01);
        check("rr_drain_out_req", out_req, 0);

        // Single grant to requester 1 brings rr_ptr back to 0
        drive(2'b10, 1'b1, 1'b0, 32'h0);
        check("pre_lock_gnt", in_gnt, 2'b10);
        drive(2'b00, 1'b0, 1'b1, 32'h0);
        check("pre_lock_rvalid", in_r_valid, 2'b10);

        // Lock: requester 1 stalled, requester 0 joins, rr_ptr=0 would otherwise pick 0
        drive(2'b10, 1'b0, 1'b0, 32'h0);
        check("lock_c0_add", out_add, 32'h2000);
        check("lock_c0_gnt", in_gnt, 0);
        check("lock_c0_wen", out_wen, 1);
        for (int k = 1; k <= 2; k++) begin
            drive(2'b11, 1'b0, 1'b0, 32'h0);
            check($sformatf("lock_c%0d_add", k), out_add, 32'h2000);
            check($sformatf("lock_c%0d_be", k), out_be, 4'hF);
            check($sformatf("lock_c%0d_req", k), out_req, 1);
        end
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        check("lock_gnt_first", in_gnt, 2'b10);
        check("lock_gnt_data", out_data, 32'hBBBB_0001);
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        check("lock_gnt_second", in_gnt, 2'b01);
        check("lock_second_data", out_data, 32'hAAAA_0000);
        drive(2'b00, 1'b0, 1'b1, 32'h0);
        check("lock_drain0", in_r_valid, 2'b10);
        drive(2'b00, 1'b0, 1'b1, 32'h0);
        check("lock_drain1", in_r_valid, 2'b01);
        check("lock_err", err_o, 0);

        // Fill the ID FIFO
        for (int k = 0; k < 4; k++) begin
            drive(2'b01, 1'b1, 1'b0, 32'h0);
            check($sformatf("full_fill%0d_outst", k), outstanding_o, k);
            check($sformatf("full_fill%0d_gnt", k), in_gnt, 2'b01);
        end
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        check("full_outst", outstanding_o, 4);
        check("full_out_req", out_req, 0);
        check("full_gnt", in_gnt, 0);
        drive(2'b01, 1'b1, 1'b1, 32'h0);
        check("full_pop_out_req", out_req, 0);
        check("full_pop_rvalid", in_r_valid, 2'b01);
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        check("full_resume_outst", outstanding_o, 3);
        check("full_resume_req", out_req, 1);
        check("full_resume_gnt", in_gnt, 2'b01);
        for (int k = 0; k < 4; k++) begin
            drive(2'b00, 1'b0, 1'b1, 32'h0);
            check($sformatf("full_drain%0d", k), in_r_valid, 2'b01);
        end
        check("full_drain_outst", outstanding_o, 1);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check("full_empty_outst", outstanding_o, 0);

        // Interleaved issue 1,0,1 with responses three cycles later
        drive(2'b10, 1'b1, 1'b0, 32'h0);
        check("il_gnt0", in_gnt, 2'b10);
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        check("il_gnt1", in_gnt, 2'b01);
        drive(2'b10, 1'b1, 1'b0, 32'h0);
        check("il_gnt2", in_gnt, 2'b10);
        drive(2'b00, 1'b0, 1'b1, 32'hCAFE_0001);
        check("il_rv0", in_r_valid, 2'b10);
        check("il_rd0", in_r_data, {2{32'hCAFE_0001}});
        drive(2'b00, 1'b0, 1'b1, 32'hCAFE_0002);
        check("il_rv1", in_r_valid, 2'b01);
        check("il_rd1", in_r_data, {2{32'hCAFE_0002}});
        drive(2'b00, 1'b0, 1'b1, 32'hCAFE_0003);
        check("il_rv2", in_r_valid, 2'b10);
        check("il_rd2", in_r_data, {2{32'hCAFE_0003}});

        // Response with nothing outstanding
        drive(2'b00, 1'b0, 1'b1, 32'h0);
        check("empty_rvalid", in_r_valid, 0);
        check("empty_err_before", err_o, 0);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check("empty_err_set", err_o, 1);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        check("empty_err_sticky", err_o, 1);

        // Reset with two outstanding
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_err", err_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        check("mid_pre_gnt0", in_gnt, 2'b01);
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        check("mid_pre_gnt1", in_gnt, 2'b10);
        drive(2'b11, 1'b0, 1'b0, 32'h0);
        check("mid_pre_outst", outstanding_o, 2);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_outst", outstanding_o, 0);
        check("mid_rst_out_req", out_req, 0);
        check("mid_rst_gnt", in_gnt, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        drive(2'b00, 1'b0, 1'b1, 32'h0);
        check("mid_late_rvalid", in_r_valid, 0);
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        check("mid_late_err", err_o, 1);
        check("mid_post_gnt", in_gnt, 2'b01);
        drive(2'b00, 1'b0, 1'b1, 32'h0);
        check("mid_post_rvalid", in_r_valid, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "bench time limit reached");
    end

endmodule
